// File: rtl/tri_bbox_scanner_if.sv
// tri_bbox_scanner_if: triangle input, latched vertices and pixel-stream handshake
interface tri_bbox_scanner_if;
  logic i_tri_valid;
  logic o_tri_ready;
  logic signed [15:0] i_x0, i_y0, i_x1, i_y1, i_x2, i_y2;
  logic signed [15:0] o_x0, o_y0, o_x1, o_y1, o_x2, o_y2;
  logic signed [15:0] o_p_x, o_p_y;
  logic o_valid;
  logic i_ready;
  logic o_last;
  logic o_busy;
  logic o_done;
  modport slave (
    input  i_tri_valid, i_x0, i_y0, i_x1, i_y1, i_x2, i_y2, i_ready,
    output o_tri_ready, o_x0, o_y0, o_x1, o_y1, o_x2, o_y2,
           o_p_x, o_p_y, o_valid, o_last, o_busy, o_done
  );
  modport master (
    output i_tri_valid, i_x0, i_y0, i_x1, i_y1, i_x2, i_y2, i_ready,
    input  o_tri_ready, o_x0, o_y0, o_x1, o_y1, o_x2, o_y2,
           o_p_x, o_p_y, o_valid, o_last, o_busy, o_done
  );
endinterface

// File: rtl/tri_bbox_scanner.sv
// tri_bbox_scanner: clips a triangle's bounding box to the screen and streams its pixels in raster order
module tri_bbox_scanner #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input logic i_clk,
  input logic i_rst_n,
  tri_bbox_scanner_if.slave bus
);
  localparam logic signed [15:0] XM = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] YM = 16'(SCREEN_H - 1);
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;
  state_t state;
  logic signed [15:0] xmin, xmax, ymin, ymax;
  logic signed [15:0] lx, hx, ly, hy;
  function automatic logic signed [15:0] mn(input logic signed [15:0] a, input logic signed [15:0] b);
    return a < b ? a : b;
  endfunction
  function automatic logic signed [15:0] mx(input logic signed [15:0] a, input logic signed [15:0] b);
    return a > b ? a : b;
  endfunction
  always_comb begin
    lx = mx(mn(mn(bus.o_x0, bus.o_x1), bus.o_x2), 16'sd0);
    hx = mn(mx(mx(bus.o_x0, bus.o_x1), bus.o_x2), XM);
    ly = mx(mn(mn(bus.o_y0, bus.o_y1), bus.o_y2), 16'sd0);
    hy = mn(mx(mx(bus.o_y0, bus.o_y1), bus.o_y2), YM);
  end
  assign bus.o_tri_ready = state == IDLE;
  assign bus.o_busy = state != IDLE;
  assign bus.o_done = state == DONE;
  assign bus.o_last = bus.o_valid && bus.o_p_x == xmax && bus.o_p_y == ymax;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      {bus.o_x0, bus.o_y0, bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2} <= '0;
      {xmin, xmax, ymin, ymax} <= '0;
      bus.o_p_x <= '0;
      bus.o_p_y <= '0;
      bus.o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_tri_valid) begin
          {bus.o_x0, bus.o_y0, bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2} <=
            {bus.i_x0, bus.i_y0, bus.i_x1, bus.i_y1, bus.i_x2, bus.i_y2};
          state <= SETUP;
        end
        SETUP: begin
          {xmin, xmax, ymin, ymax} <= {lx, hx, ly, hy};
          if (lx > hx || ly > hy) state <= DONE;
          else begin
            bus.o_p_x <= lx;
            bus.o_p_y <= ly;
            bus.o_valid <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: if (bus.o_valid && bus.i_ready) begin
          if (bus.o_last) begin
            bus.o_valid <= 1'b0;
            state <= DONE;
          end else if (bus.o_p_x < xmax) bus.o_p_x <= bus.o_p_x + 16'sd1;
          else begin
            bus.o_p_x <= xmin;
            bus.o_p_y <= bus.o_p_y + 16'sd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_bbox_scanner.sv
// tb_tri_bbox_scanner: table-driven triangle vectors plus reset and overlap sequences
module tb_tri_bbox_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tri_bbox_scanner_if bus();
  tri_bbox_scanner #(.SCREEN_W(320), .SCREEN_H(240)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int xmin, xmax, ymin, ymax, n;
    bit bp;
  } vec_t;
  vec_t tv[9];
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_tri(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
    bus.i_x0 = 16'(x0); bus.i_y0 = 16'(y0);
    bus.i_x1 = 16'(x1); bus.i_y1 = 16'(y1);
    bus.i_x2 = 16'(x2); bus.i_y2 = 16'(y2);
    bus.i_tri_valid = 1'b1;
  endtask
  task automatic run_tri(input vec_t v, input int id);
    int ex, ey, n, guard;
    bit rdy, fin, lst;
    drive_tri(v.x0, v.y0, v.x1, v.y1, v.x2, v.y2);
    guard = 0;
    while (!bus.o_tri_ready && guard < 50) begin tick; guard++; end
    chk($sformatf("v%0d_tri_ready", id), bus.o_tri_ready, 1);
    tick;
    bus.i_tri_valid = 1'b0;
    chk($sformatf("v%0d_setup_valid", id), bus.o_valid, 0);
    chk($sformatf("v%0d_setup_busy", id), bus.o_busy, 1);
    chk($sformatf("v%0d_lat_x0", id), bus.o_x0, v.x0);
    chk($sformatf("v%0d_lat_y2", id), bus.o_y2, v.y2);
    tick;
    if (v.n == 0) begin
      chk($sformatf("v%0d_empty_valid", id), bus.o_valid, 0);
      chk($sformatf("v%0d_empty_done", id), bus.o_done, 1);
    end else begin
      ex = v.xmin; ey = v.ymin; n = 0; guard = 0; fin = 0;
      while (!fin && guard < 2000) begin
        rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.i_ready = rdy;
        lst = (ex == v.xmax) && (ey == v.ymax);
        chk($sformatf("v%0d_valid", id), bus.o_valid, 1);
        chk($sformatf("v%0d_px", id), bus.o_p_x, ex);
        chk($sformatf("v%0d_py", id), bus.o_p_y, ey);
        chk($sformatf("v%0d_last", id), bus.o_last, lst);
        chk($sformatf("v%0d_done_mid", id), bus.o_done, 0);
        chk($sformatf("v%0d_hold_x1", id), bus.o_x1, v.x1);
        chk($sformatf("v%0d_hold_y1", id), bus.o_y1, v.y1);
        tick;
        guard++;
        if (rdy) begin
          n++;
          if (lst) fin = 1;
          else if (ex < v.xmax) ex++;
          else begin ex = v.xmin; ey++; end
        end
      end
      chk($sformatf("v%0d_count", id), n, v.n);
      chk($sformatf("v%0d_post_valid", id), bus.o_valid, 0);
      chk($sformatf("v%0d_post_done", id), bus.o_done, 1);
    end
    bus.i_ready = 1'b1;
    tick;
    chk($sformatf("v%0d_done_pulse", id), bus.o_done, 0);
    chk($sformatf("v%0d_idle_ready", id), bus.o_tri_ready, 1);
    chk($sformatf("v%0d_idle_busy", id), bus.o_busy, 0);
  endtask
  initial begin
    int guard;
    tv[0] = '{0, 0, 3, 0, 0, 2, 0, 3, 0, 2, 12, 1'b0};
    tv[1] = '{-5, -5, 2, -5, -5, 1, 0, 2, 0, 1, 6, 1'b0};
    tv[2] = '{300, 230, 400, 230, 300, 260, 300, 319, 230, 239, 200, 1'b0};
    tv[3] = '{320, 0, 400, 5, 500, 10, 0, 0, 0, 0, 0, 1'b0};
    tv[4] = '{5, 7, 5, 7, 5, 7, 5, 5, 7, 7, 1, 1'b0};
    tv[5] = '{0, 0, 3, 0, 0, 2, 0, 3, 0, 2, 12, 1'b1};
    tv[6] = '{-10, -3, -1, 50, -4, 2, 0, 0, 0, 0, 0, 1'b0};
    tv[7] = '{10, 240, 20, 300, 15, 250, 0, 0, 0, 0, 0, 1'b0};
    tv[8] = '{319, 239, 319, 239, 319, 239, 319, 319, 239, 239, 1, 1'b1};
    bus.i_tri_valid = 1'b0;
    bus.i_ready = 1'b1;
    drive_tri(0, 0, 0, 0, 0, 0);
    bus.i_tri_valid = 1'b0;
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_last", bus.o_last, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_px", bus.o_p_x, 0);
    chk("rst_ready", bus.o_tri_ready, 1);
    #21 rst_n = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) run_tri(tv[i], i);
    // reset asserted mid-scan must clear outputs without waiting for a clock edge
    drive_tri(0, 0, 3, 0, 0, 2);
    tick;
    bus.i_tri_valid = 1'b0;
    guard = 0;
    while (!(bus.o_valid && bus.o_p_x == 2 && bus.o_p_y == 1) && guard < 30) begin tick; guard++; end
    chk("mid_reached", int'(bus.o_p_x) * 1000 + int'(bus.o_p_y), 2001);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_last", bus.o_last, 0);
    chk("arst_px", bus.o_p_x, 0);
    chk("arst_py", bus.o_p_y, 0);
    chk("arst_x1", bus.o_x1, 0);
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_ready", bus.o_tri_ready, 1);
    #10 rst_n = 1'b1;
    tick;
    chk("rel_ready", bus.o_tri_ready, 1);
    run_tri('{10, 20, 12, 20, 10, 21, 10, 12, 20, 21, 6, 1'b0}, 20);
    // second triangle held valid through the first scan is only taken once back in IDLE
    drive_tri(0, 0, 1, 0, 0, 0);
    tick;
    drive_tri(50, 60, 50, 60, 50, 60);
    chk("ov_setup_ready", bus.o_tri_ready, 0);
    tick;
    chk("ov_scan_px0", bus.o_p_x, 0);
    chk("ov_scan_x0", bus.o_x0, 0);
    tick;
    chk("ov_scan_px1", bus.o_p_x, 1);
    chk("ov_scan_last", bus.o_last, 1);
    chk("ov_scan_ready", bus.o_tri_ready, 0);
    tick;
    chk("ov_done", bus.o_done, 1);
    chk("ov_done_x0", bus.o_x0, 0);
    tick;
    chk("ov_idle_ready", bus.o_tri_ready, 1);
    chk("ov_idle_x0", bus.o_x0, 0);
    tick;
    bus.i_tri_valid = 1'b0;
    chk("ov_accept_x0", bus.o_x0, 50);
    chk("ov_accept_busy", bus.o_busy, 1);
    tick;
    chk("ov2_px", bus.o_p_x, 50);
    chk("ov2_py", bus.o_p_y, 60);
    chk("ov2_last", bus.o_last, 1);
    guard = 0;
    while (!bus.o_done && guard < 10) begin tick; guard++; end
    chk("ov2_done", bus.o_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
